// File: rtl/seg_capture_pkg.sv
// seg_capture_pkg: segment patterns, digit codes and FSM state shared by the scan capture block
package seg_capture_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F, SEG_1 = 7'h06, SEG_2 = 7'h5B, SEG_3 = 7'h4F, SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D, SEG_6 = 7'h7D, SEG_7 = 7'h07, SEG_8 = 7'h7F, SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77, SEG_B = 7'h7C, SEG_C = 7'h39, SEG_D = 7'h5E, SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71, SEG_BLANK = 7'h00;
  localparam logic [3:0] DIG_BLANK = 4'hE, DIG_BAD = 4'hF;
  typedef enum logic [1:0] {ST_BLANK, ST_SETTLING, ST_HELD} cap_state_t;
  function automatic logic [2:0] onehot_index(input logic [7:0] v);
    onehot_index = '0;
    for (int i = 0; i < 8; i++) if (v[i]) onehot_index = 3'(i);
  endfunction
endpackage

// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: scanned display bus (an anodes, duan right-bank segments, duan1 left-bank segments); master = display driver, slave = capture
interface seg_scan_capture_if;
  logic [7:0] an;
  logic [7:0] duan;
  logic [7:0] duan1;
  modport master(output an, duan, duan1);
  modport slave(input an, duan, duan1);
endinterface

// File: rtl/seg_scan_capture_decode.sv
// seg7_decode: 7-segment pattern (seg, a=bit0..g=bit6) to digit code and bad flag; SEG_CAPTURE_HEX_EN adds A-F
module seg7_decode
  import seg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       bad
);
  always_comb begin
    code = DIG_BAD;
    bad = 1'b0;
    case (seg)
      SEG_0: code = 4'h0;
      SEG_1: code = 4'h1;
      SEG_2: code = 4'h2;
      SEG_3: code = 4'h3;
      SEG_4: code = 4'h4;
      SEG_5: code = 4'h5;
      SEG_6: code = 4'h6;
      SEG_7: code = 4'h7;
      SEG_8: code = 4'h8;
      SEG_9: code = 4'h9;
`ifdef SEG_CAPTURE_HEX_EN
      SEG_A: code = 4'hA;
      SEG_B: code = 4'hB;
      SEG_C: code = 4'hC;
      SEG_D: code = 4'hD;
      SEG_E: code = 4'hE;
      SEG_F: code = 4'hF;
`else
`endif
      SEG_BLANK: code = DIG_BLANK;
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds 8 BCD digits + dp from a scanned display bus (scan slave); outputs digits, dp, frame_valid, bad_pattern, an_error, stale; SEG_CAPTURE_HEX_EN enables hex decode
module seg_scan_capture
  import seg_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_capture_if.slave   scan,
  output logic [31:0]         digits,
  output logic [7:0]          dp,
  output logic                frame_valid,
  output logic [7:0]          bad_pattern,
  output logic                an_error,
  output logic                stale
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(FRAME_TIMEOUT);
  logic [23:0] sync1, sync2, prev;
  logic [CW-1:0] cnt, cur;
  logic [TW-1:0] tcnt;
  cap_state_t state, state_n;
  logic [7:0] an_s, seg_s, seen, seen_n, cap_bit, shadow_dp, shadow_bad;
  logic [31:0] shadow_dig;
  logic [2:0] k;
  logic [3:0] code;
  logic bad, chg, settled, capture, multi, publish, expire;
  assign an_s = sync2[23:16];
  assign k = onehot_index(an_s);
  assign seg_s = k[2] ? sync2[15:8] : sync2[7:0];
  assign chg = sync2 != prev;
  // cur counts identical samples including the current one, so a change counts as the first
  assign cur = chg ? CW'(1) : cnt >= SETTLE ? SETTLE : cnt + CW'(1);
  assign cap_bit = capture ? 8'b1 << k : '0;
  assign publish = seen == 8'hFF;
  assign expire = !capture && tcnt == TMAX - TW'(1);
  assign seen_n = expire ? '0 : (publish ? '0 : seen) | cap_bit;
  seg7_decode u_dec (.seg(seg_s[6:0]), .code(code), .bad(bad));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_BLANK;
    else state <= state_n;
  always_comb
    state_n = an_s == '0 ? ST_BLANK : settled ? ST_HELD : (chg || state == ST_BLANK) ? ST_SETTLING : state;
  // settled also fires on the change cycle itself so SETTLE_CYCLES = 1 keeps its latency
  always_comb begin
    settled = an_s != '0 && cur >= SETTLE && (state == ST_SETTLING || chg);
    capture = settled && $onehot(an_s);
    multi = settled && !$onehot(an_s);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      cnt <= '0;
      tcnt <= '0;
      seen <= '0;
      shadow_dig <= {8{DIG_BLANK}};
      shadow_dp <= '0;
      shadow_bad <= '0;
      digits <= {8{DIG_BLANK}};
      dp <= '0;
      bad_pattern <= '0;
      frame_valid <= 1'b0;
      an_error <= 1'b0;
      stale <= 1'b0;
    end else begin
      sync1 <= {scan.an, scan.duan1, scan.duan};
      sync2 <= sync1;
      prev <= sync2;
      cnt <= cur;
      tcnt <= capture ? '0 : tcnt == TMAX ? TMAX : tcnt + TW'(1);
      seen <= seen_n;
      if (capture) begin
        shadow_dig[4*k +: 4] <= code;
        shadow_dp[k] <= seg_s[7];
        shadow_bad[k] <= bad;
      end
      if (publish) begin
        digits <= shadow_dig;
        dp <= shadow_dp;
        bad_pattern <= shadow_bad;
      end
      frame_valid <= publish;
      an_error <= an_error | multi;
      stale <= !publish && (stale || expire);
    end
endmodule
